// File: rtl/hash_s_axi_regs_if.sv
// rtl/hash_s_axi_regs_if.sv - AXI4-Lite S00_AXI bundle between bus master and hash register file
interface hash_s_axi_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/hash_s_axi_regs.sv
// rtl/hash_s_axi_regs.sv - AXI4-Lite slave holding four 32-bit hash control/data registers
module hash_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    hash_s_axi_regs_if.slave                  s_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [3:0]                        reg_wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];

    logic          aw_held_q, aw_held_d;
    logic [1:0]    awsel_q, awsel_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    logic [3:0]    pulse_q, pulse_d;

    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          awready, wready, arready;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic [1:0]    wsel;
    logic [DW-1:0] wdat;
    logic [SW-1:0] wstb;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            aw_held_q <= 1'b0;
            awsel_q   <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            pulse_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
            aw_held_q <= aw_held_d;
            awsel_q   <= awsel_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            pulse_q   <= pulse_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // A pending B response blocks both write channels so only one write is ever outstanding.
    always_comb begin
        awready = !aw_held_q && !bvalid_q;
        wready  = !w_held_q && !bvalid_q;
        arready = !rvalid_q;
        aw_hs   = s_axi.S_AXI_AWVALID && awready;
        w_hs    = s_axi.S_AXI_WVALID && wready;
        ar_hs   = s_axi.S_AXI_ARVALID && arready;
        commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wsel    = aw_held_q ? awsel_q : s_axi.S_AXI_AWADDR[3:2];
        wdat    = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
        wstb    = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
        aw_held_d = aw_held_q;
        awsel_d   = awsel_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        pulse_d   = '0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awsel_d   = s_axi.S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
        end

        if (commit) begin
            aw_held_d     = 1'b0;
            w_held_d      = 1'b0;
            bvalid_d      = 1'b1;
            pulse_d[wsel] = 1'b1;
            for (int b = 0; b < SW; b++) begin
                if (wstb[b]) regs_d[wsel][8*b +: 8] = wdat[8*b +: 8];
            end
        end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Reads sample the pre-edge register array, so a same-edge write is not visible yet.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[s_axi.S_AXI_ARADDR[3:2]];
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid_q;

    assign reg_out      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
    assign reg_wr_pulse = pulse_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_hash_s_axi_regs.sv
// tb/tb_hash_s_axi_regs.sv - scoreboard bench for the hash AXI4-Lite register file
module tb_hash_s_axi_regs;
    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    hash_s_axi_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    hash_s_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .s_axi        (bus.slave),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [4];
    logic [31:0] rd_q [$];
    logic [1:0]  b_q [$];
    logic [3:0]  p_q [$];
    int pulse1_cnt = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors sample on the falling edge; handshakes complete on the following rising edge.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                if (rd_q.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    check("rdata", bus.S_AXI_RDATA, rd_q.pop_front());
                    check("rresp", bus.S_AXI_RRESP, 2'b00);
                end
            end
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (b_q.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", bus.S_AXI_BRESP, b_q.pop_front());
            end
            if (reg_wr_pulse != 4'd0) begin
                if (reg_wr_pulse[1]) pulse1_cnt++;
                if (p_q.size() == 0) check("pulse_unexpected", reg_wr_pulse, 0);
                else check("wr_pulse", reg_wr_pulse, p_q.pop_front());
            end
        end
    end

    task automatic expect_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
        b_q.push_back(2'b00);
        p_q.push_back(4'b0001 << addr[3:2]);
    endtask

    task automatic drive_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic en_aw, input logic en_w);
        logic aw_acc, w_acc;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = en_aw;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = en_w;
        for (int t = 0; t < 50 && (bus.S_AXI_AWVALID || bus.S_AXI_WVALID); t++) begin
            aw_acc = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_acc  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_acc) bus.S_AXI_AWVALID = 1'b0;
            if (w_acc)  bus.S_AXI_WVALID  = 1'b0;
        end
        if (bus.S_AXI_AWVALID || bus.S_AXI_WVALID) begin
            check("wr_timeout", 1, 0);
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
        end
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        expect_write(addr, data, strb);
        drive_wr(addr, data, strb, 1'b1, 1'b1);
    endtask

    task automatic do_read(input logic [3:0] addr);
        logic acc;
        rd_q.push_back(model[addr[3:2]]);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        for (int t = 0; t < 50 && bus.S_AXI_ARVALID; t++) begin
            acc = bus.S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (acc) bus.S_AXI_ARVALID = 1'b0;
        end
        if (bus.S_AXI_ARVALID) begin
            check("rd_timeout", 1, 0);
            bus.S_AXI_ARVALID = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1_start;
        ARESET = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) @(negedge ACLK);
        check("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        check("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        check("rst_regs", reg_out, 128'd0);
        check("rst_rdata_pulse", {bus.S_AXI_RDATA, reg_wr_pulse}, 36'd0);
        ARESET = 1'b0;
        idle(1);

        // Basic writes with AW and W together, then read-back.
        for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF);
        idle(2);
        for (int i = 0; i < 4; i++) do_read(4'(i * 4));
        idle(2);
        check("reg_out_basic", reg_out, 128'h00000004_00000003_00000002_00000001);

        // Byte strobes.
        p1_start = pulse1_cnt;
        do_write(4'h4, 32'hAABBCCDD, 4'hF);
        do_write(4'h4, 32'h11223344, 4'b0101);
        idle(2);
        check("strobe_merge", reg_out[63:32], 32'hAA22CC44);
        check("pulse1_count", pulse1_cnt - p1_start, 2);
        do_read(4'h4);
        idle(2);

        // W leads AW by three cycles.
        expect_write(4'h8, 32'h5A5A5A5A, 4'hF);
        drive_wr(4'h8, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b1);
        check("w_held_wready", bus.S_AXI_WREADY, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("w_only_no_b", bus.S_AXI_BVALID, 1'b0);
            idle(1);
        end
        drive_wr(4'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        check("w_first_bvalid", bus.S_AXI_BVALID, 1'b1);
        idle(1);
        do_read(4'h8);
        idle(2);

        // Stalled BREADY does not block reads.
        bus.S_AXI_BREADY = 1'b0;
        do_write(4'h0, 32'hCAFEF00D, 4'hF);
        do_read(4'h0);
        for (int i = 0; i < 10; i++) begin
            check("b_stall", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b100);
            idle(1);
        end
        check("read_during_stall", rd_q.size(), 0);
        bus.S_AXI_BREADY = 1'b1;
        do_write(4'h0, 32'h00000000, 4'b0000);
        idle(2);

        // Read and write commit to reg3 on the same edge.
        check("simul_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        rd_q.push_back(32'h4);
        expect_write(4'hC, 32'hDEADBEEF, 4'hF);
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 4'hC;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        idle(1);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        idle(2);
        do_read(4'hC);
        idle(2);

        // Asynchronous reset with a held AW and a pending R.
        drive_wr(4'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        bus.S_AXI_RREADY = 1'b0;
        do_read(4'h8);
        check("pre_rst_rvalid", bus.S_AXI_RVALID, 1'b1);
        #2;
        ARESET = 1'b1;
        #1;
        check("async_rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        check("async_rst_regs", reg_out, 128'd0);
        rd_q.delete(); b_q.delete(); p_q.delete();
        for (int i = 0; i < 4; i++) model[i] = '0;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        idle(1);
        drive_wr(4'h0, 32'h12345678, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_w_only", bus.S_AXI_BVALID, 1'b0);
            idle(1);
        end
        expect_write(4'h4, 32'h12345678, 4'hF);
        drive_wr(4'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        check("post_rst_bvalid", bus.S_AXI_BVALID, 1'b1);
        idle(2);
        check("post_rst_regs", reg_out, {32'd0, 32'd0, 32'h12345678, 32'd0});

        idle(4);
        check("rd_q_empty", rd_q.size(), 0);
        check("b_q_empty", b_q.size(), 0);
        check("p_q_empty", p_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hash_s_axi_regs.md
Name: hash_s_axi_regs

Overview:
- AXI4-Lite slave register file: the responder end of the S00_AXI interface that the bus master drives with single-beat writes and reads.
- Holds four 32-bit control/data registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Exposes the registers and per-register write pulses to the hash core.
- Accepts AW and W independently, in either order. One write and one read may be outstanding concurrently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] ignored

Ports:
ACLK  in  1  single clock, rising edge
ARESET  in  1  reset, asynchronous, active-high
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response, always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  128  {reg3, reg2, reg1, reg0}
reg_wr_pulse  out  4  one-cycle pulse, bit i high in the cycle after register i is written

Behaviour:

Reset:
- ARESET high asynchronously clears reg0..reg3, aw_held, w_held, BVALID, RVALID, RDATA and reg_wr_pulse to 0.
- Handshakes in flight are dropped. No response is issued for them after reset releases.

Write channel:
- State is two hold flags, aw_held and w_held, plus latched address and latched data/strobe.
- AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
- An AW handshake at an edge latches the address and sets aw_held. A W handshake latches WDATA/WSTRB and sets w_held.
- Commit edge is the first edge where an address and data are both available, from holds or from same-edge handshakes. AW and W arriving on the same edge commit on that edge.
- On the commit edge:
  - the selected register updates byte-wise per WSTRB; bytes with a zero strobe keep their old value;
  - BVALID is set;
  - both holds are cleared;
  - reg_wr_pulse[sel] is high for the following cycle only.
- Latency: the register value and BVALID are visible one cycle after the commit handshake.
- BVALID holds until BREADY. While BVALID is high, AWREADY and WREADY stay low, so only one write is outstanding.
- BVALID clears on the edge where BVALID && BREADY.
- WSTRB = 0 still produces BVALID and a reg_wr_pulse; no data changes.

Read channel:
- ARREADY = !RVALID.
- On an AR handshake, RDATA is captured from the register selected by ARADDR[3:2] and RVALID is set on the same edge.
- Latency: data valid one cycle after ARVALID && ARREADY.
- RDATA and RVALID hold stable until RREADY. RVALID clears on the edge where RVALID && RREADY.
- A new AR can be accepted no earlier than the cycle after RVALID clears. There is no back-to-back AR while RVALID is high.

Simultaneous events:
- A write commit and an AR handshake to the same register on the same edge return the pre-write value.
- The read and write channels are otherwise fully independent. A stalled BREADY never blocks reads, and a stalled RREADY never blocks writes.

Protocol invariants:
- VALID outputs never drop without the matching READY.
- RDATA, RRESP and BRESP stay stable while VALID is high.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC (AW and W together), then read back -> RDATA 0x1, 0x2, 0x3, 0x4. BRESP and RRESP 00. reg_out = 0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB = 4'b0101 -> reading 0x4 returns 0xAA22CC44. reg_wr_pulse[1] pulses once per write.
- W presented 3 cycles before AW to 0x8 with data 0x5A5A5A5A -> WREADY drops after the W handshake. Commit happens on the AW edge. BVALID the next cycle. Reading 0x8 returns 0x5A5A5A5A.
- BREADY held low 10 cycles after a write -> BVALID stays high, AWREADY and WREADY stay low. A concurrent read of 0x0 completes normally. The next write is accepted after the B handshake.
- Read of 0xC issued on the same edge as the write commit of 0xDEADBEEF to 0xC (old value 0x4) -> RDATA = 0x4. A subsequent read returns 0xDEADBEEF.
- ARESET asserted mid-cycle while aw_held = 1 and RVALID = 1 -> BVALID, RVALID and all registers are 0 immediately, before the next ACLK edge. After release, W alone produces no BVALID until a new AW arrives.
